mem_unit: RTL and testbench

//   Byte-addressable 32-bit word memory for the MIPS CPU; holds instructions/data.
//   One port with a shared address; rw selects read or write; en gates all activity.
//   Big-endian byte order (MIPS). Sits between fetch/memory stages and testbench loaders.

---
 rtl/mem_unit.sv | 111 +++++++++++
 tb/tb_mem_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// ----------------------------------------------------------------------------
// mem_unit
//   Byte-addressable 32-bit word memory for the MIPS CPU. It holds both
//   instructions and data. There is one port with a shared address. Byte order
//   is big-endian.
//
//   A word access touches bytes i, i+1, i+2 and i+3, where
//   i = (w_addr_32 - BASE_ADDR) mod DEPTH_BYTES.
//   Each of these byte indices wraps independently, so unaligned accesses and
//   accesses at the top of storage are both well defined.
//
// Parameters
//   DEPTH_BYTES   storage size in bytes (power of two, >= 4)
//   BASE_ADDR     byte address that maps to storage byte 0
//   INIT_FILE     name of the hex word image (kept for interface compatibility)
//   INIT_COUNT    number of words in INIT_IMAGE
//   INIT_IMAGE    word image loaded at time 0 when MEM_INIT_EN is defined
//
// Optional feature
//   MEM_INIT_EN   when defined, storage is preloaded from INIT_IMAGE.
//                 Word k is placed big-endian at bytes 4k..4k+3.
//                 When undefined, storage starts all-zero and only writes fill it.
//
// Ports
//   clock          in   1   system clock, rising-edge active
//   reset          in   1   asynchronous, active-high; clears only the read register
//   en             in   1   access enable (0 = idle)
//   rw             in   1   1 = read, 0 = write
//   w_addr_32      in   32  byte address of the word's most-significant byte
//   w_data_in_32   in   32  write data
//   w_data_out_32  out  32  registered read data, one cycle of latency
// ----------------------------------------------------------------------------
module mem_unit #(
    parameter int          DEPTH_BYTES = 1048576,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter              INIT_FILE   = "data.x",
    parameter int          INIT_COUNT  = 2,
    parameter logic [31:0] INIT_IMAGE [INIT_COUNT] = '{32'h0000_0001, 32'h2002_0005}
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        rw,
    input  logic [31:0] w_addr_32,
    input  logic [31:0] w_data_in_32,
    output logic [31:0] w_data_out_32
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]    mem [DEPTH_BYTES];

    logic [AW-1:0] idx0;
    logic [AW-1:0] idx1;
    logic [AW-1:0] idx2;
    logic [AW-1:0] idx3;
    logic          do_write;
    logic          do_read;
    logic [31:0]   rd_word;

    // DEPTH_BYTES is a power of two. Truncating the offset to AW bits
    // therefore gives the modulo for free. Each index is also incremented in
    // AW bits, so it wraps on its own.
    assign idx0 = AW'(w_addr_32 - BASE_ADDR);
    assign idx1 = idx0 + AW'(1);
    assign idx2 = idx0 + AW'(2);
    assign idx3 = idx0 + AW'(3);

    // If en or rw is X/Z, these evaluate to X/false in simulation.
    // The if-statements below then take the idle path.
    assign do_write = en && !rw;
    assign do_read  = en && rw;

    assign rd_word = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};

    // Storage has no reset, so its contents survive reset.
    // Writes are still suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (!reset && do_write) begin
            mem[idx0] <= w_data_in_32[31:24];
            mem[idx1] <= w_data_in_32[23:16];
            mem[idx2] <= w_data_in_32[15:8];
            mem[idx3] <= w_data_in_32[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_data_out_32 <= 32'h0;
        end else if (do_read) begin
            w_data_out_32 <= rd_word;
        end
    end

`ifdef MEM_INIT_EN
    // The image words are spread across bytes big-endian.
    // Words past the end of the image remain zero.
    initial begin
        for (int k = 0; k < DEPTH_BYTES; k++) begin
            mem[k] = 8'h00;
        end
        for (int k = 0; k < INIT_COUNT && k < DEPTH_BYTES / 4; k++) begin
            mem[4*k]     = INIT_IMAGE[k][31:24];
            mem[4*k + 1] = INIT_IMAGE[k][23:16];
            mem[4*k + 2] = INIT_IMAGE[k][15:8];
            mem[4*k + 3] = INIT_IMAGE[k][7:0];
        end
    end
`endif

endmodule

// File: tb/tb_mem_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_unit
//   Scoreboard bench for mem_unit.
//   A byte-level reference model produces the expected word whenever a read
//   is issued. That word is queued and then compared one cycle later, when
//   the registered output becomes valid.
// ----------------------------------------------------------------------------
module tb_mem_unit;

    localparam int DEPTH = 1048576;

    logic        clock;
    logic        reset;
    logic        en;
    logic        rw;
    logic [31:0] w_addr_32;
    logic [31:0] w_data_in_32;
    logic [31:0] w_data_out_32;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  model [int unsigned];
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] last_out;

    mem_unit #(
        .DEPTH_BYTES (DEPTH),
        .BASE_ADDR   (32'h0000_0000),
        .INIT_FILE   ("data.x")
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .rw            (rw),
        .w_addr_32     (w_addr_32),
        .w_data_in_32  (w_data_in_32),
        .w_data_out_32 (w_data_out_32)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned bidx(input logic [31:0] addr, input int off);
        return (int'(addr) + off) & (DEPTH - 1);
    endfunction

    function automatic logic [7:0] mbyte(input int unsigned i);
        if (model.exists(i)) return model[i];
        return 8'h00;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        return {mbyte(bidx(addr, 0)), mbyte(bidx(addr, 1)),
                mbyte(bidx(addr, 2)), mbyte(bidx(addr, 3))};
    endfunction

    // Advances one clock edge, then samples the output #1 after that edge.
    // A queued read result is compared here, because it becomes valid at
    // exactly this edge.
    task automatic step(input bit has_read);
        @(posedge clock);
        #1;
        if (has_read) begin
            last_out = exp_q.pop_front();
            chk(tag_q.pop_front(), w_data_out_32, last_out);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        en = 1'b1; rw = 1'b0; w_addr_32 = addr; w_data_in_32 = data;
        if (!reset) begin
            model[bidx(addr, 0)] = data[31:24];
            model[bidx(addr, 1)] = data[23:16];
            model[bidx(addr, 2)] = data[15:8];
            model[bidx(addr, 3)] = data[7:0];
        end
        step(1'b0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr);
        en = 1'b1; rw = 1'b1; w_addr_32 = addr; w_data_in_32 = 32'h0;
        exp_q.push_back(model_word(addr));
        tag_q.push_back(tag);
        step(1'b1);
    endtask

    task automatic idle_cycle(input logic [31:0] addr, input logic [31:0] data);
        en = 1'b0; rw = 1'b0; w_addr_32 = addr; w_data_in_32 = data;
        step(1'b0);
        chk("idle_hold", w_data_out_32, last_out);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; rw = 1'b1;
        w_addr_32 = 32'h0; w_data_in_32 = 32'h0;
        last_out = 32'h0;

        #1;
        chk("reset_pre_edge", w_data_out_32, 32'h0);
        @(posedge clock); @(posedge clock); #1;
        chk("reset_held", w_data_out_32, 32'h0);
        reset = 1'b0;

`ifdef MEM_INIT_EN
        rd("init_w0", 32'h0);
        rd("init_w1", 32'h4);
`endif

        // Aligned writes, then aligned reads.
        wr(32'h0, 32'hABCDABCD);
        wr(32'h4, 32'hDEFADEFA);
        wr(32'h8, 32'h12341234);
        rd("rd_0", 32'h0);
        rd("rd_4", 32'h4);
        rd("rd_8", 32'h8);

        // An unaligned read spans two words.
        rd("rd_unaligned_2", 32'h2);

        // With en low, nothing is written and the output holds.
        for (int k = 0; k < 3; k++) idle_cycle(32'h0, 32'hFFFFFFFF);
        rd("rd_after_idle", 32'h0);

        // A write at the top of storage wraps around to address 0.
        wr(DEPTH - 2, 32'h11223344);
        rd("rd_top", DEPTH - 2);
        rd("rd_wrap_0", 32'h0);

        // A write followed immediately by a read of the same address.
        wr(32'hC, 32'hCAFEF00D);
        rd("rd_after_wr", 32'hC);

        // Reset asserted mid-cycle: the output clears with no clock edge.
        // A write during reset is blocked, and storage is not cleared.
        reset = 1'b1;
        #1;
        chk("async_reset", w_data_out_32, 32'h0);
        wr(32'h8, 32'hDEADBEEF);
        chk("reset_blocks_out", w_data_out_32, 32'h0);
        reset = 1'b0;
        last_out = 32'h0;
        rd("rd_kept_after_reset", 32'h8);
        rd("rd_kept_wrap", 32'h0);

        // Randomised mix of writes and reads inside a region already filled.
        for (int k = 0; k < 16; k++) wr(32'h100 + 4 * k, $urandom);
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            a = 32'h100 + $urandom_range(0, 60);
            if ($urandom_range(0, 1) == 0) wr(a, $urandom);
            else rd("rd_random", a);
        end

        en = 1'b0;
        step(1'b0);
        if (exp_q.size() != 0) chk("scoreboard_drained", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

`ifdef MEM_INIT_EN
    initial begin
        model[0] = 8'h00; model[1] = 8'h00; model[2] = 8'h00; model[3] = 8'h01;
        model[4] = 8'h20; model[5] = 8'h02; model[6] = 8'h00; model[7] = 8'h05;
    end
`endif

endmodule
